apb_timer: RTL and testbench

//   APB slave peripheral: a 32-bit free-running/compare timer with prescaler and a level interrupt.

---
 rtl/apb_timer.sv | 134 +++++++++++++
 tb/tb_apb_timer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer.sv
// APB slave timer: 32-bit counter with prescaler, compare match and level interrupt.
// Bus accesses complete after a fixed number of wait states.
module apb_timer #(
  parameter int WAIT_STATES = 1,
  parameter int PRESC_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PSEL,
  input  logic        PENABLE,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        irq
);

  localparam logic [3:0] WS_C = 4'(WAIT_STATES);

  logic [3:0]         wait_cnt_r;
  logic [2:0]         ctrl_r;
  logic [PRESC_W-1:0] presc_r;
  logic [PRESC_W-1:0] pcnt_r;
  logic [31:0]        count_r;
  logic [31:0]        compare_r;
  logic               match_r;

  logic               access_s;
  logic               ready_s;
  logic [2:0]         sel_s;
  logic               tick_s;
  logic               hit_s;
  logic               wr_ctrl_s;
  logic               wr_presc_s;
  logic               wr_count_s;
  logic               wr_compare_s;
  logic               wr_status_s;
  logic [31:0]        rdata_s;
  logic               unused_s;

  assign access_s = PSEL & PENABLE;
  assign ready_s  = ~rst & access_s & (wait_cnt_r == WS_C);
  assign sel_s    = PADDR[4:2];
  assign tick_s   = ctrl_r[0] & (pcnt_r == presc_r);
  assign hit_s    = tick_s & (count_r == compare_r);
  assign unused_s = ^{PADDR[31:5], PADDR[1:0]};

  assign PREADY = ready_s;
  assign PRDATA = rdata_s;
  assign irq    = match_r & ctrl_r[2];

  // Wait-state counter: runs only while an access phase is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= 4'd0;
    end else if (access_s & ~ready_s) begin
      wait_cnt_r <= wait_cnt_r + 4'd1;
    end else begin
      wait_cnt_r <= 4'd0;
    end
  end

  // Write strobe decode, one strobe per mapped register.
  always_comb begin
    wr_ctrl_s    = 1'b0;
    wr_presc_s   = 1'b0;
    wr_count_s   = 1'b0;
    wr_compare_s = 1'b0;
    wr_status_s  = 1'b0;
    if (ready_s & PWRITE) begin
      case (sel_s)
        3'd0:    wr_ctrl_s    = 1'b1;
        3'd1:    wr_presc_s   = 1'b1;
        3'd2:    wr_count_s   = 1'b1;
        3'd3:    wr_compare_s = 1'b1;
        3'd4:    wr_status_s  = 1'b1;
        default: wr_ctrl_s    = 1'b0;
      endcase
    end else begin
      wr_ctrl_s = 1'b0;
    end
  end

  // Register file and timer; bus writes to COUNT override the tick increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_r    <= 3'd0;
      presc_r   <= '0;
      pcnt_r    <= '0;
      count_r   <= 32'd0;
      compare_r <= 32'd0;
      match_r   <= 1'b0;
    end else begin
      if (wr_ctrl_s)    ctrl_r    <= PWDATA[2:0];
      if (wr_compare_s) compare_r <= PWDATA;

      if (wr_presc_s) begin
        presc_r <= PWDATA[PRESC_W-1:0];
        pcnt_r  <= '0;
      end else if (tick_s | ~ctrl_r[0]) begin
        pcnt_r  <= '0;
      end else begin
        pcnt_r  <= pcnt_r + PRESC_W'(1);
      end

      if (wr_count_s)                count_r <= PWDATA;
      else if (hit_s & ctrl_r[1])    count_r <= 32'd0;
      else if (tick_s)               count_r <= count_r + 32'd1;

      // A new match beats a simultaneous write-1-to-clear.
      if (hit_s)                          match_r <= 1'b1;
      else if (wr_status_s & PWDATA[0])   match_r <= 1'b0;
    end
  end

  // Read mux: data is driven only in the completing cycle of a read.
  always_comb begin
    rdata_s = 32'd0;
    if (ready_s & ~PWRITE) begin
      case (sel_s)
        3'd0:    rdata_s = {29'd0, ctrl_r};
        3'd1:    rdata_s = 32'(presc_r);
        3'd2:    rdata_s = count_r;
        3'd3:    rdata_s = compare_r;
        3'd4:    rdata_s = {31'd0, match_r};
        default: rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

endmodule

// File: tb/tb_apb_timer.sv
// Bench for apb_timer: directed scenarios plus random APB traffic, checked every
// cycle against a register-level model of the timer.
module tb_apb_timer;

  localparam int WS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] paddr = 32'd0;
  logic [31:0] pwdata = 32'd0;
  logic        pwrite = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic [31:0] prdata;
  logic        pready;
  logic        irq;

  int n_checks = 0;
  int n_err = 0;

  apb_timer #(.WAIT_STATES(WS), .PRESC_W(16)) dut (
    .clk(clk), .rst(rst), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
    .PSEL(psel), .PENABLE(penable), .PRDATA(prdata), .PREADY(pready), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [2:0]  m_ctrl = 3'd0;
  logic [15:0] m_presc = 16'd0;
  logic [15:0] m_pcnt = 16'd0;
  logic [31:0] m_count = 32'd0;
  logic [31:0] m_cmp = 32'd0;
  logic        m_match = 1'b0;
  int          m_acc = 0;

  function automatic logic [31:0] m_read(input logic [2:0] idx);
    case (idx)
      3'd0:    return {29'd0, m_ctrl};
      3'd1:    return {16'd0, m_presc};
      3'd2:    return m_count;
      3'd3:    return m_cmp;
      3'd4:    return {31'd0, m_match};
      default: return 32'd0;
    endcase
  endfunction

  // Compare outputs against the model, then advance the model by one clock.
  always @(negedge clk) begin
    logic        acc, exp_ready, tick, hit, wr, n_match;
    logic [31:0] exp_rd, n_count;
    logic [15:0] n_pcnt;
    logic [2:0]  idx;
    acc = psel && penable;
    idx = paddr[4:2];
    exp_ready = !rst && acc && (m_acc == WS);
    exp_rd = (exp_ready && !pwrite) ? m_read(idx) : 32'd0;
    chk("pready", {31'd0, pready}, {31'd0, exp_ready});
    chk("prdata", prdata, exp_rd);
    chk("irq", {31'd0, irq}, {31'd0, m_match & m_ctrl[2]});
    if (rst) begin
      m_ctrl = 3'd0; m_presc = 16'd0; m_pcnt = 16'd0;
      m_count = 32'd0; m_cmp = 32'd0; m_match = 1'b0; m_acc = 0;
    end else begin
      wr = exp_ready && pwrite;
      tick = m_ctrl[0] && (m_pcnt == m_presc);
      hit = tick && (m_count == m_cmp);
      n_count = !tick ? m_count : ((hit && m_ctrl[1]) ? 32'd0 : m_count + 32'd1);
      n_pcnt = (m_ctrl[0] && !tick) ? m_pcnt + 16'd1 : 16'd0;
      n_match = hit || (m_match && !(wr && idx == 3'd4 && pwdata[0]));
      if (wr) begin
        case (idx)
          3'd0: m_ctrl = pwdata[2:0];
          3'd1: begin m_presc = pwdata[15:0]; n_pcnt = 16'd0; end
          3'd2: n_count = pwdata;
          3'd3: m_cmp = pwdata;
          default: ;
        endcase
      end
      m_count = n_count; m_pcnt = n_pcnt; m_match = n_match;
      m_acc = (acc && !exp_ready) ? m_acc + 1 : 0;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Full write: setup, WS stalled access cycles, completing cycle; returns just
  // after the commit edge.
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, input int extra = 0);
    paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    idle(1 + extra);
    penable = 1'b1;
    idle(WS + 1);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output int lows,
                          input int extra = 0);
    paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    idle(1 + extra);
    penable = 1'b1;
    lows = 0;
    repeat (WS) begin
      @(negedge clk);
      if (!pready) lows++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    d = prdata;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    logic [31:0] d, a;
    int lows, idx;

    // Reset, then reset again in the middle of a COMPARE write
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_pready", {31'd0, pready}, 32'd0);
    chk("reset_prdata", prdata, 32'd0);
    @(posedge clk); #1;
    paddr = 32'h0000_000C; pwdata = 32'h0000_ABCD; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    idle(1);
    penable = 1'b1;
    idle(1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    chk("midrst_pready", {31'd0, pready}, 32'd0);
    chk("midrst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    apb_read(32'h0000_000C, d, lows);
    chk("midrst_compare", d, 32'd0);

    // Handshake with three wait states
    apb_write(32'h0000_000C, 32'h0000_0010);
    apb_read(32'h0000_000C, d, lows, 1);
    chk("hs_readback", d, 32'h0000_0010);
    chk("hs_wait_cycles", lows, 3);

    // Prescale 4 for exactly 50 enabled cycles
    apb_write(32'h0000_0004, 32'd4);
    apb_write(32'h0000_0000, 32'h1);
    idle(45);
    apb_write(32'h0000_0000, 32'h0);
    apb_read(32'h0000_0008, d, lows);
    chk("presc_count", d, 32'd10);
    apb_write(32'h0000_0014, 32'hFFFF_FFFF);
    apb_read(32'h0000_0014, d, lows);
    chk("unmapped_read", d, 32'd0);

    // Match with auto-clear and interrupt
    apb_write(32'h0000_0008, 32'd0);
    apb_write(32'h0000_0004, 32'd0);
    apb_write(32'h0000_000C, 32'd5);
    apb_write(32'h0000_0010, 32'd1);
    apb_write(32'h0000_0000, 32'h7);
    idle(5);
    @(negedge clk);
    chk("irq_before_match", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("irq_on_match", {31'd0, irq}, 32'd1);
    @(posedge clk); #1;
    apb_write(32'h0000_0000, 32'h4);
    @(negedge clk);
    chk("irq_held", {31'd0, irq}, 32'd1);
    @(posedge clk); #1;
    apb_write(32'h0000_0010, 32'd1);
    @(negedge clk);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;

    // W1C on the match cycle: set wins
    apb_write(32'h0000_0008, 32'd0);
    apb_write(32'h0000_000C, 32'd10);
    apb_write(32'h0000_0000, 32'h1);
    idle(6);
    apb_write(32'h0000_0010, 32'd1);
    apb_read(32'h0000_0010, d, lows);
    chk("w1c_vs_match", d, 32'd1);

    // COUNT write on a tick cycle: write wins
    apb_write(32'h0000_0000, 32'h0);
    apb_write(32'h0000_0004, 32'd4);
    apb_write(32'h0000_0000, 32'h1);
    idle(5);
    apb_write(32'h0000_0008, 32'h0000_0100);
    apb_read(32'h0000_0008, d, lows);
    chk("count_write_vs_tick", d, 32'h0000_0100);

    // Wrap through 0xFFFFFFFF with no match flag
    apb_write(32'h0000_0000, 32'h0);
    apb_write(32'h0000_0010, 32'd1);
    apb_write(32'h0000_0004, 32'd0);
    apb_write(32'h0000_0008, 32'hFFFF_FFFC);
    apb_write(32'h0000_000C, 32'h0000_1234);
    apb_write(32'h0000_0000, 32'h1);
    apb_read(32'h0000_0008, d, lows);
    chk("wrap_count", d, 32'd0);
    apb_read(32'h0000_0010, d, lows);
    chk("wrap_no_match", d, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        idle($urandom_range(1, 2));
        rst = 1'b0;
      end
      idle($urandom_range(0, 3));
      idx = $urandom_range(0, 7);
      a = $urandom;
      a[4:2] = idx[2:0];
      case (idx)
        1:       d = $urandom & 32'hFFFF_0007;
        2, 3:    d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                 : $urandom_range(0, 24);
        default: d = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) apb_write(a, d, $urandom_range(0, 2));
      else apb_read(a, d, lows, $urandom_range(0, 2));
    end

    idle(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
